// File: rtl/hdlc_rx_line_monitor.sv
// Multi-channel HDLC receive-line monitor: flag/abort/idle detection, frame byte-alignment
// checking and saturating per-channel event counters behind a registered readback mux.
module hdlc_rx_line_monitor #(
   parameter int N_CH     = 4,
   parameter int CNT_W    = 16,
   parameter int IDLE_LEN = 15
) (
   input  logic                                      Clk,
   input  logic                                      Rst,
   input  logic                                      Enable,
   input  logic [N_CH-1:0]                           Rx,
   input  logic                                      Clear,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] RdCh,
   input  logic [1:0]                                RdSel,
   output logic [CNT_W-1:0]                          RdData,
   output logic [N_CH-1:0]                           FlagDetect,
   output logic [N_CH-1:0]                           AbortDetect,
   output logic [N_CH-1:0]                           AbortSignal,
   output logic [N_CH-1:0]                           FrameEnd,
   output logic [N_CH-1:0]                           FrameError,
   output logic [N_CH-1:0]                           InFrame,
   output logic [N_CH-1:0]                           Idle
);

   localparam int               RD_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int               RUN_W     = $clog2(IDLE_LEN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX   = '1;
   localparam logic [RUN_W-1:0] RUN_STUFF = RUN_W'(5);
   localparam logic [RUN_W-1:0] RUN_IDLE  = RUN_W'(IDLE_LEN);
   localparam logic [RD_W:0]    N_CH_L    = (RD_W + 1)'(N_CH);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {ST_HUNT = 1'b0, ST_FRAME = 1'b1} state_t;

   state_t           r_state      [N_CH];
   state_t           w_state_nxt  [N_CH];
   logic [7:0]       r_sr         [N_CH];
   logic [7:0]       w_sr_nxt     [N_CH];
   logic [RUN_W-1:0] r_run        [N_CH];
   logic [RUN_W-1:0] w_run_nxt    [N_CH];
   logic [4:0]       r_bitcnt     [N_CH];
   logic [4:0]       w_bitcnt_nxt [N_CH];
   logic [4:0]       w_bitcnt_adv [N_CH];
   logic [N_CH-1:0]  w_flag, w_abort, w_abs, w_end, w_err;
   logic [N_CH-1:0]  r_ev_flag, r_ev_abort, r_ev_abs, r_ev_end, r_ev_err;
   logic [CNT_W-1:0] r_cnt        [N_CH][4];
   logic             w_rd_ok;
   logic [RD_W-1:0]  w_rd_idx;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   always_comb begin
      logic [4:0] v_inc;
      v_inc   = '0;
      w_flag  = '0;
      w_abort = '0;
      w_abs   = '0;
      w_end   = '0;
      w_err   = '0;
      for (int c = 0; c < N_CH; c++) begin
         w_sr_nxt[c]  = {r_sr[c][6:0], Rx[c]};
         w_flag[c]    = (w_sr_nxt[c] == 8'h7E);
         w_abort[c]   = (w_sr_nxt[c] == 8'h7F);
         w_run_nxt[c] = !Rx[c] ? '0 : ((r_run[c] == RUN_MAX) ? r_run[c] : r_run[c] + 1'b1);
         // A 0 after exactly five 1s is transmitter bit-stuffing, not payload. Bit 4 is sticky.
         v_inc = r_bitcnt[c] + 5'd1;
         if (!Rx[c] && (r_run[c] == RUN_STUFF))
            w_bitcnt_adv[c] = r_bitcnt[c];
         else
            w_bitcnt_adv[c] = {r_bitcnt[c][4] | v_inc[4], v_inc[3:0]};
         w_state_nxt[c]  = r_state[c];
         w_bitcnt_nxt[c] = r_bitcnt[c];
         case (r_state[c])
            ST_HUNT: begin
               if (w_flag[c]) begin
                  w_state_nxt[c]  = ST_FRAME;
                  w_bitcnt_nxt[c] = '0;
               end
            end
            ST_FRAME: begin
               w_bitcnt_nxt[c] = w_bitcnt_adv[c];
               if (w_flag[c]) begin
                  // Fewer than 16 bits means back-to-back or shared flags: nothing to report.
                  w_bitcnt_nxt[c] = '0;
                  w_end[c]        = w_bitcnt_adv[c][4];
                  w_err[c]        = w_bitcnt_adv[c][4] && (w_bitcnt_adv[c][2:0] != 3'd0);
               end else if (w_abort[c]) begin
                  w_state_nxt[c] = ST_HUNT;
                  w_abs[c]       = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         for (int c = 0; c < N_CH; c++) begin
            r_state[c]  <= ST_HUNT;
            r_sr[c]     <= 8'hFF;
            r_run[c]    <= '0;
            r_bitcnt[c] <= '0;
         end
         r_ev_flag  <= '0;
         r_ev_abort <= '0;
         r_ev_abs   <= '0;
         r_ev_end   <= '0;
         r_ev_err   <= '0;
      end else if (Enable) begin
         for (int c = 0; c < N_CH; c++) begin
            r_state[c]  <= w_state_nxt[c];
            r_sr[c]     <= w_sr_nxt[c];
            r_run[c]    <= w_run_nxt[c];
            r_bitcnt[c] <= w_bitcnt_nxt[c];
         end
         r_ev_flag  <= w_flag;
         r_ev_abort <= w_abort;
         r_ev_abs   <= w_abs;
         r_ev_end   <= w_end;
         r_ev_err   <= w_err;
      end else begin
         r_ev_flag  <= '0;
         r_ev_abort <= '0;
         r_ev_abs   <= '0;
         r_ev_end   <= '0;
         r_ev_err   <= '0;
      end
   end

   // Second register stage: pulses and levels leave together, two cycles after the line bit.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         FlagDetect  <= '0;
         AbortDetect <= '0;
         AbortSignal <= '0;
         FrameEnd    <= '0;
         FrameError  <= '0;
         InFrame     <= '0;
         Idle        <= '0;
      end else begin
         FlagDetect  <= r_ev_flag;
         AbortDetect <= r_ev_abort;
         AbortSignal <= r_ev_abs;
         FrameEnd    <= r_ev_end;
         FrameError  <= r_ev_err;
         for (int c = 0; c < N_CH; c++) begin
            InFrame[c] <= (r_state[c] == ST_FRAME);
            Idle[c]    <= (r_run[c] >= RUN_IDLE);
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         for (int c = 0; c < N_CH; c++)
            for (int k = 0; k < 4; k++)
               r_cnt[c][k] <= '0;
      end else if (Clear) begin
         for (int c = 0; c < N_CH; c++)
            for (int k = 0; k < 4; k++)
               r_cnt[c][k] <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (r_ev_end[c] && !r_ev_err[c]) r_cnt[c][0] <= sat_inc(r_cnt[c][0]);
            if (r_ev_end[c] && r_ev_err[c])  r_cnt[c][1] <= sat_inc(r_cnt[c][1]);
            if (r_ev_abs[c])                 r_cnt[c][2] <= sat_inc(r_cnt[c][2]);
            if (r_ev_flag[c])                r_cnt[c][3] <= sat_inc(r_cnt[c][3]);
         end
      end
   end

   assign w_rd_ok  = ({1'b0, RdCh} < N_CH_L);
   assign w_rd_idx = w_rd_ok ? RdCh : '0;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) RdData <= '0;
      else      RdData <= w_rd_ok ? r_cnt[w_rd_idx][RdSel] : '0;
   end

endmodule

// File: tb/tb_hdlc_rx_line_monitor.sv
// Randomised and directed bench for hdlc_rx_line_monitor: a bit-level HDLC reference model
// predicts every output cycle and counter readback; a monitor process compares them.
module tb_hdlc_rx_line_monitor;

   localparam int N_CH     = 4;
   localparam int CNT_W    = 4;
   localparam int IDLE_LEN = 15;
   localparam int EW       = 32 + 7 * N_CH;
   localparam int RW       = 32 + 4 + CNT_W;
   localparam int CMAX     = (1 << CNT_W) - 1;

   logic             Clk = 1'b0;
   logic             Rst, Enable, Clear;
   logic [N_CH-1:0]  Rx;
   logic [1:0]       RdCh, RdSel;
   logic [CNT_W-1:0] RdData;
   logic [N_CH-1:0]  FlagDetect, AbortDetect, AbortSignal, FrameEnd, FrameError, InFrame, Idle;

   hdlc_rx_line_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .IDLE_LEN(IDLE_LEN)) u_dut (
      .Clk(Clk), .Rst(Rst), .Enable(Enable), .Rx(Rx), .Clear(Clear), .RdCh(RdCh), .RdSel(RdSel),
      .RdData(RdData), .FlagDetect(FlagDetect), .AbortDetect(AbortDetect),
      .AbortSignal(AbortSignal), .FrameEnd(FrameEnd), .FrameError(FrameError),
      .InFrame(InFrame), .Idle(Idle));

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;
   logic [EW-1:0] exp_q[$];
   logic [RW-1:0] rd_q[$];

   // Reference model: plain integers per channel (last 8 bits, ones run, payload bit count).
   int m_hist [N_CH];
   int m_ones [N_CH];
   int m_nbits[N_CH];
   int m_cnt  [N_CH][4];
   bit m_frame[N_CH];
   bit pend   [N_CH][$];

   function automatic void model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_hist[c] = 255; m_ones[c] = 0; m_nbits[c] = 0; m_frame[c] = 1'b0;
         for (int k = 0; k < 4; k++) m_cnt[c][k] = 0;
      end
   endfunction

   function automatic void bump(input int c, input int k);
      if (m_cnt[c][k] < CMAX) m_cnt[c][k] = m_cnt[c][k] + 1;
   endfunction

   task automatic tick(input bit en, input logic [N_CH-1:0] rx, input bit clr,
                       input int rdch, input int rdsel);
      logic [N_CH-1:0] ef, ea, es, ee, er, fr, id;
      int prev;
      @(posedge Clk); #2;
      Enable = en; Rx = rx; Clear = clr; RdCh = 2'(rdch); RdSel = 2'(rdsel);
      ef = '0; ea = '0; es = '0; ee = '0; er = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (en) begin
            prev      = m_ones[c];
            m_hist[c] = ((m_hist[c] * 2) + int'(rx[c])) % 256;
            m_ones[c] = rx[c] ? m_ones[c] + 1 : 0;
            if (m_frame[c] && !(rx[c] == 1'b0 && prev == 5)) m_nbits[c] = m_nbits[c] + 1;
            if (m_hist[c] == 126) begin
               ef[c] = 1'b1;
               bump(c, 3);
               if (m_frame[c] && m_nbits[c] >= 16) begin
                  ee[c] = 1'b1;
                  er[c] = (m_nbits[c] % 8) != 0;
                  bump(c, er[c] ? 1 : 0);
               end
               m_frame[c] = 1'b1;
               m_nbits[c] = 0;
            end else if (m_hist[c] == 127) begin
               ea[c] = 1'b1;
               if (m_frame[c]) begin
                  es[c] = 1'b1;
                  bump(c, 2);
                  m_frame[c] = 1'b0;
               end
            end
         end
         fr[c] = m_frame[c];
         id[c] = (m_ones[c] >= IDLE_LEN);
      end
      if (clr)
         for (int c = 0; c < N_CH; c++)
            for (int k = 0; k < 4; k++) m_cnt[c][k] = 0;
      exp_q.push_back({32'(cyc + 2), ef, ea, es, ee, er, fr, id});
   endtask

   task automatic send(input int ch, input logic [63:0] bits, input int n, input bit clr);
      logic [N_CH-1:0] rx;
      for (int i = n - 1; i >= 0; i--) begin
         rx     = '1;
         rx[ch] = bits[i];
         tick(1'b1, rx, clr, 0, 0);
      end
   endtask

   task automatic read_all();
      repeat (3) tick(1'b0, '1, 1'b0, 0, 0);
      for (int ch = 0; ch < N_CH; ch++)
         for (int sel = 0; sel < 4; sel++) begin
            tick(1'b0, '1, 1'b0, ch, sel);
            rd_q.push_back({32'(cyc + 1), 2'(ch), 2'(sel), CNT_W'(m_cnt[ch][sel])});
         end
   endtask

   task automatic reset_check(input string name);
      logic [7*N_CH+CNT_W-1:0] got;
      got = {FlagDetect, AbortDetect, AbortSignal, FrameEnd, FrameError, InFrame, Idle, RdData};
      checks++;
      if (got !== '0) begin
         failures++;
         $display("FAIL %s got=%h exp=0", name, got);
      end
   endtask

   task automatic mid_reset();
      @(posedge Clk); #2;
      Rst = 1'b0;
      exp_q.delete();
      rd_q.delete();
      #1 reset_check("mid_reset");
      model_reset();
      @(posedge Clk); #2;
      Rst = 1'b1;
   endtask

   task automatic push_byte(input int c, input logic [7:0] v);
      for (int i = 7; i >= 0; i--) pend[c].push_back(v[i]);
   endtask

   task automatic refill(input int c);
      int k, n, ones;
      bit b;
      k = $urandom_range(0, 9);
      ones = 0;
      if (k <= 3) push_byte(c, 8'h7E);
      else if (k == 4) push_byte(c, 8'h7F);
      else if (k == 5) begin
         n = $urandom_range(8, 20);
         repeat (n) pend[c].push_back(1'b1);
      end else if (k <= 8) begin
         n = (k == 6) ? 8 * $urandom_range(2, 5) : $urandom_range(1, 40);
         for (int i = 0; i < n; i++) begin
            b = 1'($urandom_range(0, 1));
            pend[c].push_back(b);
            ones = b ? ones + 1 : 0;
            if (ones == 5) begin
               pend[c].push_back(1'b0);
               ones = 0;
            end
         end
      end else begin
         n = $urandom_range(1, 24);
         repeat (n) pend[c].push_back(1'($urandom_range(0, 1)));
      end
   endtask

   always @(negedge Clk) begin
      logic [EW-1:0]       e;
      logic [RW-1:0]       r;
      logic [7*N_CH-1:0]   got;
      if (Rst === 1'b1) begin
         while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
            e = exp_q.pop_front();
            checks++; failures++;
            $display("FAIL stale_out cyc=%0d tag=%0d", cyc, int'(e[EW-1 -: 32]));
         end
         if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
            e   = exp_q.pop_front();
            got = {FlagDetect, AbortDetect, AbortSignal, FrameEnd, FrameError, InFrame, Idle};
            checks++;
            if (got !== e[7*N_CH-1:0]) begin
               failures++;
               $display("FAIL line_out cyc=%0d got=%h exp=%h (flag,abrt,abs,end,err,infr,idle)",
                        cyc, got, e[7*N_CH-1:0]);
            end
         end
         if (rd_q.size() > 0 && int'(rd_q[0][RW-1 -: 32]) == cyc) begin
            r = rd_q.pop_front();
            checks++;
            if (RdData !== r[CNT_W-1:0]) begin
               failures++;
               $display("FAIL rd_data ch=%0d sel=%0d got=%0d exp=%0d",
                        r[CNT_W+3 -: 2], r[CNT_W+1 -: 2], RdData, r[CNT_W-1:0]);
            end
         end
      end
   end

   initial begin
      logic [N_CH-1:0] rx;
      bit en;
      Rst = 1'b0; Enable = 1'b0; Rx = '1; Clear = 1'b0; RdCh = '0; RdSel = '0;
      model_reset();
      repeat (3) @(posedge Clk);
      #1 reset_check("reset_state");
      @(posedge Clk); #2;
      Rst = 1'b1;

      // Idle then opening flag.
      send(0, '1, 16, 1'b0);
      send(0, 64'h7E, 8, 1'b0);
      read_all();
      // Good frame FF,3C with one stuffed zero.
      send(0, 64'h7E, 8, 1'b0);
      send(0, 64'b11111011100111100, 17, 1'b0);
      send(0, 64'h7E, 8, 1'b0);
      read_all();
      // Misaligned frame of 13 bits.
      send(0, 64'h7E, 8, 1'b0);
      send(0, 64'b1010101010101, 13, 1'b0);
      send(0, 64'h7E, 8, 1'b0);
      read_all();
      // Abort inside a frame, then abort while hunting.
      send(0, 64'h7E, 8, 1'b0);
      send(0, 64'hA5, 8, 1'b0);
      send(0, 64'h7F, 8, 1'b0);
      send(0, 64'h7F, 8, 1'b0);
      read_all();
      // Idle threshold, drop out of idle, Enable low freezes everything.
      send(0, 64'h0, 1, 1'b0);
      send(0, '1, 15, 1'b0);
      send(0, 64'h0, 1, 1'b0);
      repeat (5) tick(1'b0, N_CH'($urandom), 1'b0, 0, 0);
      send(0, '1, 3, 1'b0);
      // Counter saturation, Clear against a coincident flag, reset mid-frame.
      repeat (20) send(3, 64'h7E, 8, 1'b0);
      read_all();
      send(3, 64'b0111111, 7, 1'b0);
      send(3, 64'h0, 1, 1'b1);
      send(3, 64'b11, 2, 1'b1);
      read_all();
      send(3, 64'h7E, 8, 1'b0);
      send(3, 64'h5A, 8, 1'b0);
      mid_reset();
      read_all();

      for (int round = 0; round < 4; round++) begin
         repeat (2) tick(1'b0, '1, 1'b0, 0, 0);
         tick(1'b0, '1, 1'(round % 2), 0, 0);
         for (int t = 0; t < 400; t++) begin
            en = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < N_CH; c++) begin
               if (en) begin
                  if (pend[c].size() == 0) refill(c);
                  rx[c] = pend[c].pop_front();
               end else begin
                  rx[c] = 1'($urandom_range(0, 1));
               end
            end
            tick(en, rx, 1'b0, 0, 0);
         end
         read_all();
      end

      repeat (4) @(posedge Clk);
      #1;
      checks++;
      if (exp_q.size() != 0 || rd_q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d/%0d exp=0/0", exp_q.size(), rd_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
